// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data, occupancy count and
// one-cycle overflow/underflow pulses for rejected requests. Rev 1.0
`default_nettype none

module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_op,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_W:0]       count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  // Storage is deliberately not reset; stale entries are unreachable until rewritten.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_op   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + ADDR_W'(1);
        data_op <= mem[rd_ptr];
      end
      if (wr_ok && !rd_ok) begin
        count <= count + (ADDR_W+1)'(1);
      end else if (rd_ok && !wr_ok) begin
        count <= count - (ADDR_W+1)'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed stimulus with a queue scoreboard for sync_fifo
// (DEPTH=8, DATA_WIDTH=32).
`default_nettype none

module tb_sync_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_in = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] data_op;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int failures = 0;

  logic [31:0] q [$];
  logic [31:0] exp_dout = '0;

  sync_fifo #(.DATA_WIDTH(32), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .data_op   (data_op),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input logic eo, input logic eu);
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == 8));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("overflow", 32'(overflow), 32'(eo));
    chk("underflow", 32'(underflow), 32'(eu));
    chk("data_op", data_op, exp_dout);
  endtask

  // One clock: drive at edge+1, model from pre-edge state, check at next edge+1.
  task automatic cycle(input logic w, input logic r, input logic [31:0] d);
    logic wok, rok, eo, eu;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    wok = w && (q.size() != 8);
    rok = r && (q.size() != 0);
    eo  = w && (q.size() == 8);
    eu  = r && (q.size() == 0);
    @(posedge clk);
    #1;
    if (rok) exp_dout = q.pop_front();
    if (wok) q.push_back(d);
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_state(eo, eu);
  endtask

  task automatic model_reset();
    q.delete();
    exp_dout = '0;
  endtask

  initial begin
    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_state(1'b0, 1'b0);
    rst = 1'b1;

    // Asynchronous reset asserted mid-cycle with data held
    cycle(1'b1, 1'b0, 32'h0000_00F1);
    cycle(1'b1, 1'b0, 32'h0000_00F2);
    cycle(1'b0, 1'b1, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_state(1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(1'b0, 1'b1, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);

    // Fill, overflow, drain
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 32'(i));
    chk("fill_full", 32'(full), 32'd1);
    cycle(1'b1, 1'b0, 32'hDEAD_BEEF);
    cycle(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 32'h0);
    chk("drain_last", data_op, 32'h0000_0008);

    // Wrap-around
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h10 + 32'(i));
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'hA0 + 32'(i));
    chk("wrap_full", 32'(full), 32'd1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 32'h0);
    chk("wrap_last", data_op, 32'h0000_00A7);
    chk("wrap_empty", 32'(empty), 32'd1);

    // Simultaneous read/write at count=3
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h30 + 32'(i));
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 32'hB0 + 32'(i));
    chk("simul_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'h0);

    // Both requests while empty: write wins, read rejected
    cycle(1'b1, 1'b1, 32'h0000_00C0);
    chk("empty_rw_count", 32'(count), 32'd1);

    // Both requests while full: read wins, oldest returned
    for (int i = 1; i < 8; i++) cycle(1'b1, 1'b0, 32'hC0 + 32'(i));
    cycle(1'b1, 1'b1, 32'h0000_00EE);
    chk("full_rw_oldest", data_op, 32'h0000_00C0);
    chk("full_rw_count", 32'(count), 32'd7);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 32'h0);

    // Reset pulse mid-operation
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h40 + 32'(i));
    cycle(1'b0, 1'b1, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    check_state(1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h1234_5678);
    cycle(1'b0, 1'b1, 32'h0);
    chk("post_reset_data", data_op, 32'h1234_5678);
    cycle(1'b0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sync_fifo.md
# sync_fifo

Synchronous single-clock FIFO that is the design under test behind the team's FIFO verification interface. It accepts write requests carrying `data_in` and read requests, returns read data on `data_op`, and reports `full` and `empty` status. The block is the responder to the driver and monitor clocking blocks: both sample its outputs and drive its inputs around the rising edge of `clk`. It also adds an occupancy count and one-cycle error pulses for rejected requests, which the scoreboard checks.

## Interface

Parameters:
- `DATA_WIDTH`, default 32: width of `data_in` and `data_op`.
- `DEPTH`, default 8: number of entries. Must be a power of two, at least 2.
- `ADDR_W`, derived as log2(`DEPTH`): pointer width. Not overridable.

Ports:
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst` input 1: reset, asynchronous assert, active-low. Release is synchronous to `clk`.
- `data_in` input `DATA_WIDTH`: write data, sampled when a write is accepted.
- `wr_en` input 1: write request.
- `rd_en` input 1: read request.
- `data_op` output `DATA_WIDTH`: registered read data.
- `full` output 1: high when the FIFO holds `DEPTH` entries.
- `empty` output 1: high when the FIFO holds 0 entries.
- `count` output `ADDR_W`+1: current occupancy, 0..`DEPTH`.
- `overflow` output 1: one-cycle pulse when a write is rejected.
- `underflow` output 1: one-cycle pulse when a read is rejected.

## Operation

- Storage:
  - `DEPTH` x `DATA_WIDTH` register array.
  - Write pointer `wr_ptr` and read pointer `rd_ptr`, each `ADDR_W` bits wide.
  - Both pointers wrap naturally from `DEPTH`-1 to 0.
- Accept rules, evaluated on each rising edge from pre-edge state:
  - `wr_ok` = `wr_en` and not `full`.
  - `rd_ok` = `rd_en` and not `empty`.
- On `wr_ok`: `mem[wr_ptr]` <= `data_in`, and `wr_ptr` increments.
- On `rd_ok`: `data_op` <= `mem[rd_ptr]`, and `rd_ptr` increments.
- When there is no `rd_ok`, `data_op` holds its previous value.
- Count update:
  - `wr_ok` only: +1.
  - `rd_ok` only: -1.
  - Both or neither: unchanged.
- Flags:
  - `full` = (`count` == `DEPTH`).
  - `empty` = (`count` == 0).
  - Both are decoded from the registered `count`, so they change on the same edge as `count`.
- Simultaneous `wr_en` and `rd_en`:
  - Neither full nor empty: both accepted, `count` unchanged.
  - Empty: the write is accepted and the read is rejected. There is no fall-through; `underflow` pulses and `count` goes to 1.
  - Full: the read is accepted and the write is rejected. `overflow` pulses and `count` goes to `DEPTH`-1.
- Error pulses:
  - `overflow` <= `wr_en` and `full`.
  - `underflow` <= `rd_en` and `empty`.
  - Each is registered, high for exactly one cycle per rejected request, and not sticky.
  - A rejected request changes no other state.
- Reset (`rst` low), at any time including mid-burst:
  - `wr_ptr`, `rd_ptr` and `count` go to 0.
  - `empty` = 1, `full` = 0.
  - `data_op` = 0.
  - `overflow` = 0, `underflow` = 0.
  - Memory contents are not cleared. They are unobservable until rewritten.

## Timing

- Inputs are driven 1 time unit after a rising edge and sampled at the next rising edge.
- Outputs settle within the same cycle, so they are stable well before the 1-unit input skew of the monitor.
- Read latency: with `rd_ok` at edge N, the data is on `data_op` after edge N and is sampled by the monitor at edge N+1.
- Write-to-read: with `wr_ok` at edge N into an empty FIFO:
  - `empty` falls after edge N.
  - The earliest accepted read is at edge N+1.
  - That data appears on `data_op` after edge N+1.
- Full latency: the `DEPTH`-th accepted write at edge N raises `full` after edge N. A write at edge N+1 is rejected.
- Throughput: one write and one read per cycle, sustained, when neither full nor empty.
- `count`, `full`, `empty`, `overflow` and `underflow` all update on the same edge as the causing request.

## Test plan

Each scenario uses `DEPTH`=8 and `DATA_WIDTH`=32.

- Reset state: assert `rst`=0 mid-cycle.
  - Outputs go immediately to `empty`=1, `full`=0, `count`=0, `data_op`=0, `overflow`=0, `underflow`=0.
  - After release, a read gives `underflow`=1 for one cycle and `count` stays 0.
- Fill and overflow: write 0x00000001..0x00000008 on 8 consecutive edges.
  - `full`=1 and `count`=8 after the 8th edge.
  - A 9th write of 0xDEADBEEF gives `overflow`=1 for one cycle and `count` stays 8.
  - Draining then returns 1..8 in order; 0xDEADBEEF never appears.
- Wrap-around: write 5 words, read 5, then write 0xA0..0xA7 (8 words, pointers wrap).
  - `full`=1.
  - Reading 8 words returns 0xA0..0xA7 in order, then `empty`=1.
- Simultaneous read/write:
  - At `count`=3, `wr_en`=`rd_en`=1 for 10 cycles: `count` stays 3 and data stays in order.
  - When empty, both high: `underflow`=1 and `count`=1.
  - When full, both high: `overflow`=1, `count`=7, and the oldest word is returned.
- Reset mid-operation: after 4 writes (`count`=4), pulse `rst` low for one cycle.
  - Result: `count`=0, `empty`=1, `data_op`=0.
  - A following write of 0x12345678 and read return 0x12345678.
